// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and types for the program loader.
//   state_e            - loader FSM state encoding
//   SYNC_BYTE_DEFAULT  - default frame start marker
//   WORD_W             - instruction word width in bits
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         WORD_W            = 16;

endpackage

// File: rtl/prog_loader_gap.sv
// gap_timer: byte-gap watchdog for the program loader.
//   clk, reset : clock and synchronous active-high reset
//   enable     : count only while a frame is in progress; counter held at 0 otherwise
//   kick       : a byte arrived this cycle; restarts the count
//   expired    : this is the TIMEOUT_CYC-th consecutive cycle without a byte
module gap_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of byte-less cycles already elapsed; the cycle on
  // which it equals TERM is the TIMEOUT_CYC-th one. A kick on that same cycle
  // wins, so a byte at the terminal count is never lost.
  always_comb begin
    expired = enable && !kick && (cnt_q == TERM);
    cnt_d   = cnt_q + 1'b1;
    if (!enable || kick || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program over a byte stream and writes it into
// instruction memory, holding the processor in reset until a frame verifies.
// Frame: SYNC_BYTE, N, N x {hi, lo}, C where C = XOR of the 2N data bytes.
//   clk, reset          : clock, synchronous active-high reset
//   rx_valid, rx_data   : one-cycle byte strobe and byte
//   mem_we              : one-cycle write strobe per received word
//   mem_addr, mem_wdata : word index within the frame and the {hi,lo} word
//   cpu_reset           : high except after a verified frame
//   load_done           : verified frame loaded (sticky until reset)
//   err                 : last frame failed (length, checksum or byte gap)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              err
);

  // Wide enough for both N (8 bits) and 2^ADDR_W, so the length check and the
  // word index never overflow.
  localparam int               CNT_W     = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              err_q, err_d;

  logic              timer_en;
  logic              expired;

  assign timer_en = (state_q == LEN) || (state_q == DATA_HI) ||
                    (state_q == DATA_LO) || (state_q == CHECK);

  gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .kick   (rx_valid),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE, ERROR: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = LEN;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      LEN: begin
        if (rx_valid) begin
          len_d = CNT_W'(rx_data);
          if ((rx_data == 8'd0) || (CNT_W'(rx_data) > MAX_WORDS)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA_HI;
          end
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      DATA_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = DATA_LO;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      DATA_LO: begin
        if (rx_valid) begin
          csum_d      = csum_q ^ rx_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_W-1:0];
          mem_wdata_d = {hi_q, rx_data};
          if ((idx_q + 1'b1) == len_q) begin
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DATA_HI;
          end
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? DONE : ERROR;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they change on the
    // same edge that accepts the deciding byte.
    load_done_d = (state_d == DONE);
    err_d       = (state_d == ERROR);
    cpu_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames plus randomized frames for prog_loader,
// checked every cycle against a byte-position reference model of the protocol.
module tb_prog_loader;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        err;

  prog_loader #(
    .ADDR_W     (8),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .load_done(load_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: tracks position within the frame rather than FSM states.
  // mode: 0 hunting for sync, 1 inside a frame, 2 loaded, 3 failed.
  int          m_mode = 0;
  int          m_pos = 0;
  int          m_n = 0;
  int          m_gap = 0;
  logic [7:0]  m_hi = 8'h00;
  logic [7:0]  m_x = 8'h00;
  logic        m_we = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_wdata = 16'h0000;

  logic [23:0] wlog[$];
  logic [7:0]  fr[$];

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    int k;
    m_we = 1'b0;
    if (r) begin
      m_mode  = 0;
      m_addr  = 8'h00;
      m_wdata = 16'h0000;
      m_gap   = 0;
    end else begin
      case (m_mode)
        0, 3: begin
          if (v && d == 8'hA5) begin
            m_mode = 1;
            m_pos  = 0;
            m_x    = 8'h00;
            m_gap  = 0;
          end
        end
        1: begin
          if (v) begin
            m_gap = 0;
            m_pos++;
            if (m_pos == 1) begin
              m_n = int'(d);
              if (m_n == 0 || m_n > 256) m_mode = 3;
            end else if (m_pos <= 2 * m_n + 1) begin
              k   = m_pos - 2;
              m_x = m_x ^ d;
              if (k % 2 == 0) begin
                m_hi = d;
              end else begin
                m_we    = 1'b1;
                m_addr  = 8'(k / 2);
                m_wdata = {m_hi, d};
              end
            end else begin
              m_mode = (d == m_x) ? 2 : 3;
            end
          end else begin
            m_gap++;
            if (m_gap == TIMEOUT) m_mode = 3;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    reset    = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(r, v, d);
    @(negedge clk);
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("flags{err,done,cpu_rst}", 32'({err, load_done, cpu_reset}),
        32'({m_mode == 3, m_mode == 2, m_mode != 2}));
    if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
    reset    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    wlog.delete();
  endtask

  task automatic send_fr(input int gap);
    for (int i = 0; i < fr.size(); i++) begin
      cycle(1'b0, 1'b1, fr[i]);
      repeat (gap) cycle(1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);

    // Good two-word frame
    fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_fr(0);
    chk("ok_nwrites", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      chk("ok_w0", 32'(wlog[0]), 32'h00_1234);
      chk("ok_w1", 32'(wlog[1]), 32'h01_ABCD);
    end
    chk("ok_done", 32'(load_done), 32'd1);
    chk("ok_cpu_reset", 32'(cpu_reset), 32'd0);

    // Bad checksum
    do_reset();
    fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_fr(1);
    chk("badc_nwrites", wlog.size(), 32'd2);
    chk("badc_flags", 32'({err, load_done, cpu_reset}), 32'b101);

    // Zero length, then recovery from error
    do_reset();
    fr = '{8'hA5, 8'h00};
    send_fr(0);
    chk("n0_err", 32'(err), 32'd1);
    chk("n0_nwrites", wlog.size(), 32'd0);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_fr(0);
    chk("rec_nwrites", wlog.size(), 32'd1);
    if (wlog.size() == 1) chk("rec_w0", 32'(wlog[0]), 32'h00_0007);
    chk("rec_flags", 32'({err, load_done, cpu_reset}), 32'b010);

    // Byte-gap timeout, then a byte exactly at the terminal count
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h12};
    send_fr(0);
    repeat (TIMEOUT - 1) cycle(1'b0, 1'b0, 8'h00);
    chk("to_not_yet", 32'(err), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    chk("to_err", 32'(err), 32'd1);
    do_reset();
    send_fr(0);
    repeat (TIMEOUT - 1) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h34);
    chk("term_no_err", 32'(err), 32'd0);
    chk("term_nwrites", wlog.size(), 32'd1);
    cycle(1'b0, 1'b1, 8'h26);
    chk("term_done", 32'(load_done), 32'd1);

    // Garbage before sync; bytes after DONE ignored
    do_reset();
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_fr(0);
    chk("garb_flags", 32'({err, load_done, cpu_reset}), 32'b001);
    fr = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_fr(0);
    chk("garb_done", 32'(load_done), 32'd1);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_fr(0);
    chk("sticky_nwrites", wlog.size(), 32'd1);
    chk("sticky_flags", 32'({err, load_done, cpu_reset}), 32'b010);

    // Reset mid-frame
    do_reset();
    fr = '{8'hA5, 8'h02, 8'h12};
    send_fr(0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("mid_rst_flags", 32'({err, load_done, cpu_reset}), 32'b001);
    fr = '{8'h34, 8'hAB, 8'hCD, 8'h40};
    send_fr(0);
    chk("mid_rst_nwrites", wlog.size(), 32'd0);
    chk("mid_rst_done", 32'(load_done), 32'd0);

    // Randomized frames: good, bad checksum, zero length, reset cut, timeout cut
    for (int it = 0; it < 30; it++) begin
      int kind, n, cut;
      logic [7:0] x, b;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0 || (m_mode == 2 && $urandom_range(0, 3) != 0))
        cycle(1'b1, 1'b0, 8'h00);
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        cycle(1'b0, 1'b1, b);
      end
      fr.delete();
      fr.push_back(8'hA5);
      n = (kind == 0) ? 0 : $urandom_range(1, 6);
      fr.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        fr.push_back(b);
      end
      if (n != 0) fr.push_back((kind == 1) ? (x ^ (8'h01 << $urandom_range(0, 7))) : x);
      cut = (kind == 2 || kind == 3) ? $urandom_range(1, fr.size() - 1) : fr.size();
      for (int i = 0; i < fr.size(); i++) begin
        if (i == cut) begin
          if (kind == 2) cycle(1'b1, 1'b0, 8'h00);
          else repeat (TIMEOUT) cycle(1'b0, 1'b0, 8'h00);
        end
        cycle(1'b0, 1'b1, fr[i]);
        repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 8'h00);
      end
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, meaning maximum clk cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data holds a new byte this cycle; a one-cycle pulse per byte.
REQ-007 SHALL have port rx_data, input, 8 bits: incoming serial byte.
REQ-008 SHALL have port mem_we, output, 1 bit: instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: word address for mem_we.
REQ-010 SHALL have port mem_wdata, output, 16 bits: instruction word for mem_we.
REQ-011 SHALL have port cpu_reset, output, 1 bit: drives the processor reset; high holds the processor in reset.
REQ-012 SHALL have port load_done, output, 1 bit: program loaded and verified.
REQ-013 SHALL have port err, output, 1 bit: last frame failed.

Function
REQ-014 SHALL accept the frame SYNC_BYTE, N (word count), 2N data bytes (high byte then low byte per word), then checksum C.
REQ-015 SHALL require C equal to the XOR of all 2N data bytes.
REQ-016 SHALL implement FSM states IDLE, LEN, DATA_HI, DATA_LO, CHECK, DONE and ERROR.
REQ-017 SHALL, in IDLE, move to LEN on rx_valid with SYNC_BYTE and discard any other byte.
REQ-018 SHALL, in LEN, latch N and go to DATA_HI; N=0 goes to ERROR.
REQ-019 SHALL treat N greater than 2^ADDR_W as an error (unreachable with the default width).
REQ-020 SHALL, in DATA_HI, latch the high byte and go to DATA_LO.
REQ-021 SHALL, on accepting the low byte in DATA_LO, assert mem_we on the next cycle for exactly one cycle.
REQ-022 SHALL present mem_addr equal to the word index (0..N-1) and mem_wdata equal to {hi,lo} during that cycle.
REQ-023 SHALL, after word N-1, go to CHECK; otherwise return to DATA_HI.
REQ-024 SHALL ensure mem_addr never wraps within a frame.
REQ-025 SHALL, in CHECK, go to DONE if C matches and to ERROR otherwise.
REQ-026 SHALL hold mem_we=0 outside the write cycles of REQ-021.
REQ-027 SHALL, in DONE, register load_done=1 and cpu_reset=0 starting the cycle after C is accepted.
REQ-028 SHALL make DONE sticky until reset, ignoring all further bytes.
REQ-029 SHALL, in ERROR, hold err=1 and cpu_reset=1.
REQ-030 SHALL, on a SYNC_BYTE received in ERROR, clear err and go to LEN, restarting from address 0; other bytes are ignored.
REQ-031 SHALL run a byte-gap timeout counter in LEN, DATA_HI, DATA_LO and CHECK that clears on every rx_valid.
REQ-032 SHALL go to ERROR when that counter reaches TIMEOUT_CYC without an rx_valid.
REQ-033 SHALL hold the timeout counter at 0 in IDLE, DONE and ERROR.
REQ-034 SHALL, if rx_valid coincides with the timeout terminal count, process the byte and not time out.
REQ-035 SHALL keep cpu_reset=1 in every state except DONE.

Reset
REQ-036 SHALL, with reset high at a clk edge, go to IDLE with mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, load_done=0, err=0, checksum accumulator=0 and timeout counter=0.
REQ-037 SHALL let reset mid-frame abort the frame with no further mem_we; words already written are not reverted.

Structure
REQ-038 SHALL place the FSM state encoding, the SYNC_BYTE default and the 16-bit word width constant in the shared processor package.
REQ-039 SHALL implement the byte-gap timeout as one sub-module, gap_timer, with inputs clk, reset, enable and kick and output expired.

Verification
REQ-040 SHALL cover: frame A5 02 12 34 AB CD 40 -> writes 0x1234 at 0 and 0xABCD at 1; load_done=1 and cpu_reset=0 one cycle after 40.
REQ-041 SHALL cover: the same frame with C=41 -> both words written, then err=1, cpu_reset=1 and load_done=0.
REQ-042 SHALL cover: A5 00 -> err=1 with no mem_we; then a valid A5 01 00 07 07 -> err clears, 0x0007 written at 0, then load_done=1.
REQ-043 SHALL cover: A5 01 12, then TIMEOUT_CYC idle cycles -> err=1; a byte arriving at the terminal count is accepted instead.
REQ-044 SHALL cover: garbage bytes 00 FF 5A before A5 in IDLE -> ignored; a byte after DONE -> no mem_we and no state change.
REQ-045 SHALL cover: reset asserted after the first data byte -> IDLE next cycle, outputs at reset values, and no mem_we.
